va_034_qctl: RTL and testbench
==============================

// Module: va_034_qctl
// PURPOSE
//  Clocked MPI/Q-bus slave cycle controller for the VP1-034 device cluster.
//  Sits upstream of the bus register and PIO stages and beside the address/vector decoder.
//  Consumes the decoder select (nSB) and raw bus strobes, then drives register output
//  enable (nDME), register write strobe (C) and bus reply (nRPLY).
//  Also owns the interrupt request/acknowledge daisy-chain handshake.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth for nSYNC/nDIN/nDOUT/nIAKI/nSB (legal 2..4)
//  RPLY_DLY     2  cycles from nDME asserted to nRPLY asserted on reads/vector reads (1..15)
//  WR_PW        2  width of C pulse in cycles on writes (1..15); nRPLY asserts as C falls
// PORTS
//  PIN_CLK    in   1  single clock, all state on rising edge
//  PIN_nRST   in   1  asynchronous active-low reset
//  PIN_nSYNC  in   1  bus address strobe, active low, asynchronous
//  PIN_nDIN   in   1  bus read strobe, active low, asynchronous
//  PIN_nDOUT  in   1  bus write strobe, active low, asynchronous
//  PIN_nIAKI  in   1  interrupt acknowledge in (daisy chain), active low
//  PIN_nSB    in   1  device select from address decoder, active low, valid while nSYNC low
//  PIN_IRQ    in   1  device interrupt request, level, active high, synchronous to PIN_CLK
//  PIN_nRPLY  out  1  bus reply, active low (1 = released)
//  PIN_nDME   out  1  register read-out enable, active low
//  PIN_C      out  1  register write strobe, active high
//  PIN_nVIRQ  out  1  interrupt request to bus, active low
//  PIN_nIAKO  out  1  interrupt acknowledge passed down chain, active low
//  PIN_nVEN   out  1  vector drive enable to vector stage, active low
//  PIN_ACK    out  1  one-cycle pulse: request acknowledged, vector delivered
// BEHAVIOUR
//  Reset: async. Outputs are nRPLY=1, nDME=1, C=0, nVIRQ=1, nIAKO=1, nVEN=1, ACK=0.
//   The FSM enters IDLE, the counter clears, the pending latch clears and the synchronizers preset to negated.
//   Reset mid-cycle releases all outputs immediately, without waiting for a clock.
//  Inputs are inverted to active-high sync_s/din_s/dout_s/iak_s/sel_s after SYNC_STAGES flops.
//  T0 is the first cycle in which a synchronized strobe reads 1. All outputs are registered.
//  FSM states: IDLE, ADDR, RD, WR, RPLY, IAKW, VEC, PASS.
//   IDLE: when sync_s=1, go to ADDR if sel_s=1, otherwise stay in IDLE (cycle not ours).
//         If iak_s=1 and din_s=1 while sync_s=0, go to IAKW.
//   ADDR: din_s only -> RD. dout_s only -> WR. Both or neither -> hold. sync_s=0 -> IDLE.
//   RD: nDME=0 from T0+1. Counter loads RPLY_DLY. nRPLY=0 at T0+1+RPLY_DLY, then go to RPLY.
//   WR: C=1 from T0+1 for WR_PW cycles. At T0+1+WR_PW, C=0 and nRPLY=0 on the same edge; go to RPLY.
//   RPLY: hold nRPLY=0 (and nDME=0 if reading) until the active strobe's _s reads 0.
//         Next cycle, release both. Return to ADDR if sync_s=1 (read-modify-write), else IDLE.
//   Abort: if the strobe negates in RD or WR before reply, release all outputs next cycle.
//         Then go to ADDR or IDLE; C never exceeds WR_PW.
//  Interrupt:
//   pend is set when IRQ=1 in IDLE, and cleared by ACK or by IRQ=0 outside IAKW/VEC.
//   nVIRQ = ~pend, registered.
//   IAKW decides arbitration once, in the cycle of entry:
//    - pend=1 -> VEC: nVEN=0 and counter=RPLY_DLY; nRPLY=0 after RPLY_DLY cycles.
//      Held until iak_s or din_s is 0, then release. ACK=1 for the release cycle and pend clears.
//    - pend=0 -> PASS: nIAKO=0 until iak_s=0, then nIAKO=1 and go to IDLE.
//   An IRQ rising after IAKW entry does not steal the acknowledge; it is served next time.
//  Counter is 4 bits, saturates at 0, and never wraps.
//  nRPLY is never asserted in IDLE or ADDR.
//  nDME and C are never active together.
//  nVEN and nDME are never active together.
// TESTING
//  Read, RPLY_DLY=2: nSYNC low, nSB=0, then nDIN low.
//   -> nDME=0 at T0+1, nRPLY=0 at T0+3, both =1 one cycle after din_s drops.
//  Write, WR_PW=2: nSYNC low, nSB=0, then nDOUT low.
//   -> C=1 for exactly 2 cycles, nRPLY=0 on C fall, release after dout_s drops.
//  Unselected: nSB=1 with a full read cycle.
//   -> nRPLY, nDME and C stay released for the whole cycle.
//  Abort and reset: nDIN pulse of 1 cycle.
//   -> nDME released, no nRPLY, return to ADDR.
//   nRST low during WR -> C=0 immediately, with no clock edge.
//  Interrupt served: IRQ=1, then nDIN and nIAKI low.
//   -> nVEN=0, nRPLY=0 after 2 cycles, one ACK pulse, nVIRQ=1 afterwards, nIAKO stays 1.
//  Interrupt passed: IRQ=0 at IAK, then IRQ=1 mid-IAK.
//   -> nIAKO=0 until nIAKI rises, no nRPLY, nVIRQ asserts afterwards.

Source files
------------

// File: rtl/va_034_qctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : va_034_qctl_if
//  Description : Bus-side signal bundle for the VP1-034 Q-bus slave cycle
//                controller.
//                Slave side (the controller) receives:
//                  n_sync, n_din, n_dout, n_iaki, n_sb (all active low)
//                  irq (active high, synchronous to the controller clock)
//                Slave side (the controller) drives:
//                  n_rply, n_dme, n_virq, n_iako, n_ven (all active low)
//                  c (active high), ack (active high, one-cycle pulse)
//  Revision    : 1.0  initial release
// ============================================================================
interface va_034_qctl_if;
    logic n_sync;
    logic n_din;
    logic n_dout;
    logic n_iaki;
    logic n_sb;
    logic irq;
    logic n_rply;
    logic n_dme;
    logic c;
    logic n_virq;
    logic n_iako;
    logic n_ven;
    logic ack;

    modport slave (
        input  n_sync, n_din, n_dout, n_iaki, n_sb, irq,
        output n_rply, n_dme, c, n_virq, n_iako, n_ven, ack
    );

    modport master (
        output n_sync, n_din, n_dout, n_iaki, n_sb, irq,
        input  n_rply, n_dme, c, n_virq, n_iako, n_ven, ack
    );
endinterface
`default_nettype wire

// File: rtl/va_034_qctl.sv
`default_nettype none
// ============================================================================
//  Module      : va_034_qctl
//  Description : Clocked MPI/Q-bus slave cycle controller. Synchronizes the
//                raw bus strobes and the decoder select, runs the data-cycle
//                FSM (register read-out enable, write strobe, bus reply) and
//                the interrupt request / acknowledge daisy-chain handshake.
//  Ports       : clk   - single clock, all state on rising edge
//                rst_n - asynchronous active-low reset
//                bus   - va_034_qctl_if.slave (strobes in, reply/enables out)
//  Parameters  : SYNC_STAGES - synchronizer depth (2..4)
//                RPLY_DLY    - cycles from n_dme/n_ven asserted to n_rply (1..15)
//                WR_PW       - width of the c pulse on writes (1..15)
//  Revision    : 1.0  initial release
// ============================================================================
module va_034_qctl #(
    parameter int SYNC_STAGES = 2,
    parameter int RPLY_DLY    = 2,
    parameter int WR_PW       = 2
) (
    input  wire          clk,
    input  wire          rst_n,
    va_034_qctl_if.slave bus
);

    localparam logic [3:0] c_rply_dly = 4'(RPLY_DLY);
    localparam logic [3:0] c_wr_pw    = 4'(WR_PW);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_RPLY = 3'd4,
        S_IAKW = 3'd5,
        S_VEC  = 3'd6,
        S_PASS = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. Bit order: {n_sb, n_iaki, n_dout, n_din, n_sync}.
    // Preset to all-ones so every strobe reads negated out of reset.
    // ------------------------------------------------------------------
    logic [4:0] w_raw;
    logic [4:0] r_pipe [SYNC_STAGES];
    logic [4:0] w_act;

    assign w_raw = {bus.n_sb, bus.n_iaki, bus.n_dout, bus.n_din, bus.n_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_pipe[i] <= '1;
            end
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_act = ~r_pipe[SYNC_STAGES-1];

    logic w_sync_s, w_din_s, w_dout_s, w_iak_s, w_sel_s;
    assign w_sync_s = w_act[0];
    assign w_din_s  = w_act[1];
    assign w_dout_s = w_act[2];
    assign w_iak_s  = w_act[3];
    assign w_sel_s  = w_act[4];

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_is_rd;
    logic       r_pend;
    logic       r_n_rply;
    logic       r_n_dme;
    logic       r_c;
    logic       r_n_virq;
    logic       r_n_iako;
    logic       r_n_ven;
    logic       r_ack;

    // Vector delivered and the acknowledging master has let go: this is the
    // edge that produces ACK and retires the pending request.
    logic w_vec_done;
    assign w_vec_done = (r_state == S_VEC) && (!w_iak_s || !w_din_s) && !r_n_rply;

    // Pending request. A request is only captured while idle, and the
    // IAKW/VEC window is frozen so the arbitration decision cannot be
    // disturbed by irq moving mid-acknowledge.
    logic w_pend_next;
    always_comb begin
        w_pend_next = r_pend;
        if (w_vec_done) begin
            w_pend_next = 1'b0;
        end else if (bus.irq && (r_state == S_IDLE)) begin
            w_pend_next = 1'b1;
        end else if (!bus.irq && (r_state != S_IAKW) && (r_state != S_VEC)) begin
            w_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= 1'b0;
            r_n_virq <= 1'b1;
        end else begin
            r_pend   <= w_pend_next;
            r_n_virq <= ~w_pend_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_is_rd  <= 1'b0;
            r_n_rply <= 1'b1;
            r_n_dme  <= 1'b1;
            r_c      <= 1'b0;
            r_n_iako <= 1'b1;
            r_n_ven  <= 1'b1;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sync_s) begin
                        if (w_sel_s) begin
                            r_state <= S_ADDR;
                        end
                    end else if (w_iak_s && w_din_s) begin
                        r_state <= S_IAKW;
                    end
                end

                S_ADDR: begin
                    if (!w_sync_s) begin
                        r_state <= S_IDLE;
                    end else if (w_din_s && !w_dout_s) begin
                        r_state <= S_RD;
                        r_n_dme <= 1'b0;
                        r_cnt   <= c_rply_dly;
                        r_is_rd <= 1'b1;
                    end else if (w_dout_s && !w_din_s) begin
                        r_state <= S_WR;
                        r_c     <= 1'b1;
                        r_cnt   <= c_wr_pw;
                        r_is_rd <= 1'b0;
                    end
                end

                // Abort has priority over the reply countdown.
                S_RD: begin
                    if (!w_din_s) begin
                        r_n_dme <= 1'b1;
                        r_state <= w_sync_s ? S_ADDR : S_IDLE;
                    end else if (r_cnt <= 4'd1) begin
                        r_n_rply <= 1'b0;
                        r_state  <= S_RPLY;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                // c falls on the same edge that raises the reply.
                S_WR: begin
                    if (!w_dout_s) begin
                        r_c     <= 1'b0;
                        r_state <= w_sync_s ? S_ADDR : S_IDLE;
                    end else if (r_cnt <= 4'd1) begin
                        r_c      <= 1'b0;
                        r_n_rply <= 1'b0;
                        r_state  <= S_RPLY;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_RPLY: begin
                    if (!(r_is_rd ? w_din_s : w_dout_s)) begin
                        r_n_rply <= 1'b1;
                        r_n_dme  <= 1'b1;
                        r_state  <= w_sync_s ? S_ADDR : S_IDLE;
                    end
                end

                // Single-cycle arbitration point for the acknowledge.
                S_IAKW: begin
                    if (r_pend) begin
                        r_state <= S_VEC;
                        r_n_ven <= 1'b0;
                        r_cnt   <= c_rply_dly;
                    end else begin
                        r_state  <= S_PASS;
                        r_n_iako <= 1'b0;
                    end
                end

                // r_n_rply doubles as the "vector already replied" flag.
                S_VEC: begin
                    if (!w_iak_s || !w_din_s) begin
                        r_n_ven  <= 1'b1;
                        r_n_rply <= 1'b1;
                        r_ack    <= ~r_n_rply;
                        r_state  <= S_IDLE;
                    end else if (r_n_rply) begin
                        if (r_cnt <= 4'd1) begin
                            r_n_rply <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end

                S_PASS: begin
                    if (!w_iak_s) begin
                        r_n_iako <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.n_rply = r_n_rply;
    assign bus.n_dme  = r_n_dme;
    assign bus.c      = r_c;
    assign bus.n_virq = r_n_virq;
    assign bus.n_iako = r_n_iako;
    assign bus.n_ven  = r_n_ven;
    assign bus.ack    = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_va_034_qctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_va_034_qctl
//  Description : Scoreboard bench for va_034_qctl. Stimulus pushes the
//                expected output transitions (output, new value, cycle);
//                a negedge monitor matches every observed output change
//                against that queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_va_034_qctl;

    localparam int SYNC_STAGES = 2;
    localparam int RPLY_DLY    = 2;
    localparam int WR_PW       = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   mon_en;

    typedef struct {
        int bit_idx;
        bit val;
        int at;
    } exp_t;

    exp_t exp_q[$];

    va_034_qctl_if bus();

    va_034_qctl #(
        .SYNC_STAGES (SYNC_STAGES),
        .RPLY_DLY    (RPLY_DLY),
        .WR_PW       (WR_PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit order: 0 n_rply, 1 n_dme, 2 c, 3 n_virq, 4 n_iako, 5 n_ven, 6 ack
    function automatic string bit_name(int b);
        case (b)
            0: return "n_rply";
            1: return "n_dme";
            2: return "c";
            3: return "n_virq";
            4: return "n_iako";
            5: return "n_ven";
            default: return "ack";
        endcase
    endfunction

    task automatic expect_at(int b, bit v, int at);
        exp_t e;
        e.bit_idx = b;
        e.val     = v;
        e.at      = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_drained(string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected transitions never seen, first %s->%0b at cycle %0d",
                     name, exp_q.size(), bit_name(exp_q[0].bit_idx), exp_q[0].val, exp_q[0].at);
            exp_q.delete();
        end
    endtask

    task automatic check_bit(string name, logic act, logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [6:0] prev;
    always @(negedge clk) begin
        logic [6:0] cur;
        int         found;
        exp_t       e;
        cur = {bus.ack, bus.n_ven, bus.n_iako, bus.n_virq, bus.c, bus.n_dme, bus.n_rply};
        if (mon_en) begin
            for (int b = 0; b < 7; b++) begin
                if (cur[b] !== prev[b]) begin
                    found = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (found < 0 && exp_q[i].bit_idx == b) found = i;
                    end
                    n_checks++;
                    if (found < 0) begin
                        n_fail++;
                        $display("FAIL unexpected %s: went to %0b at cycle %0d, required no change",
                                 bit_name(b), cur[b], cyc);
                    end else begin
                        e = exp_q[found];
                        exp_q.delete(found);
                        if (e.val !== cur[b] || e.at != cyc) begin
                            n_fail++;
                            $display("FAIL %s: got %0b at cycle %0d, required %0b at cycle %0d",
                                     bit_name(b), cur[b], cyc, e.val, e.at);
                        end
                    end
                end
            end
            if (cur[1] === 1'b0 && cur[2] === 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL excl_dme_c: both active at cycle %0d, required exclusive", cyc);
            end
            if (cur[1] === 1'b0 && cur[5] === 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL excl_dme_ven: both active at cycle %0d, required exclusive", cyc);
            end
        end
        prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t;
        n_checks   = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        bus.n_sync = 1'b1;
        bus.n_din  = 1'b1;
        bus.n_dout = 1'b1;
        bus.n_iaki = 1'b1;
        bus.n_sb   = 1'b1;
        bus.irq    = 1'b0;
        tick(3);

        check_bit("rst_n_rply", bus.n_rply, 1'b1);
        check_bit("rst_n_dme",  bus.n_dme,  1'b1);
        check_bit("rst_c",      bus.c,      1'b0);
        check_bit("rst_n_virq", bus.n_virq, 1'b1);
        check_bit("rst_n_iako", bus.n_iako, 1'b1);
        check_bit("rst_n_ven",  bus.n_ven,  1'b1);
        check_bit("rst_ack",    bus.ack,    1'b0);
        rst_n = 1'b1;
        tick(2);
        mon_en = 1'b1;
        tick(2);

        // Read: n_dme at T0+1, n_rply at T0+3, release 3 cycles after n_din rises
        bus.n_sync = 1'b0; bus.n_sb = 1'b0;
        tick(3);
        t = cyc; bus.n_din = 1'b0;
        expect_at(1, 1'b0, t + 3);
        expect_at(0, 1'b0, t + 5);
        tick(7);
        t = cyc; bus.n_din = 1'b1;
        expect_at(0, 1'b1, t + 3);
        expect_at(1, 1'b1, t + 3);
        tick(4);
        bus.n_sync = 1'b1; bus.n_sb = 1'b1;
        tick(6);
        check_drained("read");

        // Write: c for two cycles, n_rply as c falls
        bus.n_sync = 1'b0; bus.n_sb = 1'b0;
        tick(3);
        t = cyc; bus.n_dout = 1'b0;
        expect_at(2, 1'b1, t + 3);
        expect_at(2, 1'b0, t + 5);
        expect_at(0, 1'b0, t + 5);
        tick(7);
        t = cyc; bus.n_dout = 1'b1;
        expect_at(0, 1'b1, t + 3);
        tick(4);
        bus.n_sync = 1'b1; bus.n_sb = 1'b1;
        tick(6);
        check_drained("write");

        // Unselected read: nothing may move
        bus.n_sync = 1'b0; bus.n_sb = 1'b1;
        tick(3);
        bus.n_din = 1'b0;
        tick(7);
        bus.n_din = 1'b1;
        tick(4);
        bus.n_sync = 1'b1;
        tick(6);
        check_drained("unsel");
        check_bit("unsel_n_rply", bus.n_rply, 1'b1);
        check_bit("unsel_n_dme",  bus.n_dme,  1'b1);
        check_bit("unsel_c",      bus.c,      1'b0);

        // Abort: one-cycle n_din pulse, then a full read from ADDR
        bus.n_sync = 1'b0; bus.n_sb = 1'b0;
        tick(3);
        t = cyc; bus.n_din = 1'b0;
        expect_at(1, 1'b0, t + 3);
        expect_at(1, 1'b1, t + 4);
        tick(1);
        bus.n_din = 1'b1;
        tick(5);
        t = cyc; bus.n_din = 1'b0;
        expect_at(1, 1'b0, t + 3);
        expect_at(0, 1'b0, t + 5);
        tick(7);
        t = cyc; bus.n_din = 1'b1;
        expect_at(0, 1'b1, t + 3);
        expect_at(1, 1'b1, t + 3);
        tick(4);
        bus.n_sync = 1'b1; bus.n_sb = 1'b1;
        tick(6);
        check_drained("abort");

        // Reset mid-write: c drops with no clock edge
        bus.n_sync = 1'b0; bus.n_sb = 1'b0;
        tick(3);
        t = cyc; bus.n_dout = 1'b0;
        expect_at(2, 1'b1, t + 3);
        tick(4);
        check_bit("wr_c_before_rst", bus.c, 1'b1);
        #1;
        rst_n = 1'b0;
        expect_at(2, 1'b0, cyc);
        #1;
        check_bit("rst_async_c", bus.c, 1'b0);
        bus.n_sync = 1'b1; bus.n_dout = 1'b1; bus.n_sb = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(6);
        check_drained("rst_wr");

        // Interrupt served
        t = cyc; bus.irq = 1'b1;
        expect_at(3, 1'b0, t + 1);
        tick(2);
        t = cyc; bus.n_din = 1'b0; bus.n_iaki = 1'b0;
        expect_at(5, 1'b0, t + 4);
        expect_at(0, 1'b0, t + 6);
        tick(8);
        t = cyc; bus.n_din = 1'b1; bus.n_iaki = 1'b1; bus.irq = 1'b0;
        expect_at(0, 1'b1, t + 3);
        expect_at(3, 1'b1, t + 3);
        expect_at(5, 1'b1, t + 3);
        expect_at(6, 1'b1, t + 3);
        expect_at(6, 1'b0, t + 4);
        tick(8);
        check_drained("irq_served");

        // Interrupt passed down the chain; late irq served afterwards
        t = cyc; bus.n_din = 1'b0; bus.n_iaki = 1'b0;
        expect_at(4, 1'b0, t + 4);
        tick(5);
        bus.irq = 1'b1;
        tick(3);
        t = cyc; bus.n_din = 1'b1; bus.n_iaki = 1'b1;
        expect_at(4, 1'b1, t + 3);
        expect_at(3, 1'b0, t + 4);
        tick(6);
        t = cyc; bus.irq = 1'b0;
        expect_at(3, 1'b1, t + 1);
        tick(4);
        check_drained("irq_passed");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
